// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: default widths,
// condition codes and FSM state encoding.
package branch_resolve_unit_pkg;

  localparam int DATA_W_DEF       = 18;
  localparam int OFF_W_DEF        = 10;
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_LT = 3'b011,
    COND_GT = 3'b100,
    COND_LE = 3'b101,
    COND_GE = 3'b110,
    COND_NV = 3'b111
  } cond_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RESOLVE = 2'b01,
    ST_FLUSH   = 2'b10
  } state_t;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluation against the {gt,lt,eq} flags.
// Multi-bit or empty flag patterns are evaluated literally.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic gt, lt, eq;

  assign gt = flags[2];
  assign lt = flags[1];
  assign eq = flags[0];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = eq;
      COND_NE: taken = ~eq;
      COND_LT: taken = lt;
      COND_GT: taken = gt;
      COND_LE: taken = lt | eq;
      COND_GE: taken = gt | eq;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: accepts one branch at a time, decides it against the
// flag register, produces the next PC and holds flush after taken branches.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int OFF_W        = OFF_W_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gt,
  input  logic              lt,
  input  logic              eq,
  input  logic              flag_we,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [DATA_W-1:0] pc,
  input  logic [OFF_W-1:0]  offset,
  output logic              res_valid,
  output logic              taken,
  output logic [DATA_W-1:0] target,
  output logic              flush,
  output logic [2:0]        flags
);

  state_t            state;
  logic [2:0]        flag_reg;
  logic [2:0]        cond_q;
  logic [DATA_W-1:0] pc_q;
  logic [OFF_W-1:0]  off_q;
  logic [2:0]        flush_cnt;
  logic              cond_taken;
  logic              in_resolve;
  logic [DATA_W-1:0] off_ext;
  logic [DATA_W-1:0] target_taken;
  logic [DATA_W-1:0] target_seq;

  branch_cond_eval u_cond_eval (
    .cond  (cond_q),
    .flags (flag_reg),
    .taken (cond_taken)
  );

  assign off_ext      = {{(DATA_W-OFF_W){off_q[OFF_W-1]}}, off_q};
  assign target_taken = pc_q + off_ext;
  assign target_seq   = pc_q + DATA_W'(1);

  // The decision reads the flag register live during RESOLVE, so a CMP in
  // the accept cycle is seen and one in the RESOLVE cycle is not.
  assign in_resolve = (state == ST_RESOLVE);
  assign res_valid  = in_resolve;
  assign taken      = in_resolve & cond_taken;
  assign target     = in_resolve ? (cond_taken ? target_taken : target_seq) : '0;
  assign flush      = (state == ST_FLUSH);
  assign flags      = flag_reg;
  assign br_ready   = (state == ST_IDLE) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      flag_reg  <= 3'b000;
      cond_q    <= 3'b000;
      pc_q      <= '0;
      off_q     <= '0;
      flush_cnt <= 3'd0;
    end else begin
      if (flag_we) begin
        flag_reg <= {gt, lt, eq};
      end
      case (state)
        ST_IDLE: begin
          if (br_valid) begin
            cond_q <= br_cond;
            pc_q   <= pc;
            off_q  <= offset;
            state  <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          if (cond_taken) begin
            flush_cnt <= 3'(FLUSH_CYCLES - 1);
            state     <= ST_FLUSH;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 3'd0) begin
            state <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected results are queued at
// branch accept and compared when res_valid strobes.
module tb_branch_resolve_unit;

  localparam int DW = 18;
  localparam int OW = 10;
  localparam int FC = 2;

  typedef struct packed {
    logic          tk;
    logic [DW-1:0] tg;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          gt, lt, eq;
  logic          flag_we;
  logic          br_valid;
  logic          br_ready;
  logic [2:0]    br_cond;
  logic [DW-1:0] pc;
  logic [OW-1:0] offset;
  logic          res_valid;
  logic          taken;
  logic [DW-1:0] target;
  logic          flush;
  logic [2:0]    flags;

  int   vectors;
  int   miscompares;
  exp_t exp_q[$];
  logic [2:0] flag_model;

  branch_resolve_unit #(.DATA_W(DW), .OFF_W(OW), .FLUSH_CYCLES(FC)) dut (
    .clk       (clk),
    .rst       (rst),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .flag_we   (flag_we),
    .br_valid  (br_valid),
    .br_ready  (br_ready),
    .br_cond   (br_cond),
    .pc        (pc),
    .offset    (offset),
    .res_valid (res_valid),
    .taken     (taken),
    .target    (target),
    .flush     (flush),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] c, input logic [2:0] f);
    logic g, l, e;
    {g, l, e} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return e;
      3'd2: return ~e;
      3'd3: return l;
      3'd4: return g;
      3'd5: return l | e;
      3'd6: return g | e;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DW-1:0] sext(input logic [OW-1:0] o);
    return {{(DW-OW){o[OW-1]}}, o};
  endfunction

  // Result monitor: pops the scoreboard on every strobe, and checks that the
  // qualified outputs stay zero otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_res_valid", 32'(res_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("taken", 32'(taken), 32'(e.tk));
        checkOutput("target", 32'(target), 32'(e.tg));
      end
    end else begin
      checkOutput("idle_taken", 32'(taken), 32'd0);
      checkOutput("idle_target", 32'(target), 32'd0);
    end
  end

  task automatic doCmp(input logic [2:0] f);
    @(negedge clk);
    flag_we = 1'b1;
    {gt, lt, eq} = f;
    @(negedge clk);
    flag_we = 1'b0;
    flag_model = f;
    checkOutput("flags_load", 32'(flags), 32'(f));
  endtask

  task automatic applyStimulus(input logic [2:0] c, input logic [DW-1:0] p, input logic [OW-1:0] o,
                               input bit acc_we, input logic [2:0] acc_f,
                               input bit res_we, input logic [2:0] res_f);
    bit got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (br_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("ready_wait", 32'd0, 32'd1);
    br_valid = 1'b1;
    br_cond  = c;
    pc       = p;
    offset   = o;
    if (acc_we) begin
      flag_we = 1'b1;
      {gt, lt, eq} = acc_f;
      flag_model = acc_f;
    end
    e.tk = model_taken(c, flag_model);
    e.tg = e.tk ? p + sext(o) : p + DW'(1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    flag_we  = 1'b0;
    if (res_we) begin
      flag_we = 1'b1;
      {gt, lt, eq} = res_f;
    end
    @(negedge clk);
    checkOutput("resolve_valid", 32'(res_valid), 32'd1);
    checkOutput("resolve_ready", 32'(br_ready), 32'd0);
    checkOutput("resolve_flush", 32'(flush), 32'd0);
    @(posedge clk);
    #1;
    if (res_we) begin
      flag_we = 1'b0;
      flag_model = res_f;
    end
    for (int i = 0; i < (e.tk ? FC : 0); i++) begin
      @(negedge clk);
      checkOutput("flush_on", 32'(flush), 32'd1);
      checkOutput("flush_ready", 32'(br_ready), 32'd0);
    end
    @(negedge clk);
    checkOutput("flush_off", 32'(flush), 32'd0);
    checkOutput("ready_back", 32'(br_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    vectors = 0;
    miscompares = 0;
    flag_model = 3'b000;
    rst = 1'b1;
    {gt, lt, eq} = 3'b000;
    flag_we = 1'b0;
    br_valid = 1'b0;
    br_cond = 3'd0;
    pc = '0;
    offset = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(br_ready), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    checkOutput("rst_flush", 32'(flush), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("release_ready", 32'(br_ready), 32'd1);

    // CMP eq, then BEQ +5: taken with a two-cycle flush
    doCmp(3'b001);
    applyStimulus(3'b001, 18'h00100, 10'd5, 1'b0, 3'b000, 1'b0, 3'b000);

    // lt set, BGE at the top of the PC space: not taken, PC+1 wraps to 0
    doCmp(3'b010);
    applyStimulus(3'b110, 18'h3FFFF, 10'd3, 1'b0, 3'b000, 1'b0, 3'b000);

    // BLT -16 with lt written in the accept cycle
    doCmp(3'b001);
    applyStimulus(3'b011, 18'h00010, 10'h3F0, 1'b1, 3'b010, 1'b0, 3'b000);

    // BLT again with eq written during RESOLVE: old lt flag decides
    applyStimulus(3'b011, 18'h00200, 10'h3F0, 1'b0, 3'b000, 1'b1, 3'b001);
    checkOutput("flags_after_resolve_we", 32'(flags), 32'h1);

    // All conditions against each one-hot flag pattern
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 3; k++) begin
        applyStimulus(3'(c), DW'($urandom), OW'($urandom), 1'b1, 3'(1 << k), 1'b0, 3'b000);
      end
    end

    // Reset in the second flush cycle aborts the branch
    doCmp(3'b001);
    @(negedge clk);
    br_valid = 1'b1;
    br_cond  = 3'b000;
    pc       = 18'h01000;
    offset   = 10'd7;
    e.tk = 1'b1;
    e.tg = 18'h01007;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_flush1", 32'(flush), 32'd1);
    @(posedge clk);
    #2;
    checkOutput("abort_flush2", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_flush_drop", 32'(flush), 32'd0);
    checkOutput("abort_flags", 32'(flags), 32'd0);
    checkOutput("abort_ready", 32'(br_ready), 32'd0);
    flag_model = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_release_ready", 32'(br_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("abort_no_flush", 32'(flush), 32'd0);
    end

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 18, meaning PC and target width.
REQ-002 The block SHALL have parameter OFF_W, default 10, meaning signed branch-offset width.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush is held after a taken branch (legal range 1..7).
REQ-004 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: gt, lt, eq  in  1 each  flags from the 18-bit comparator stage.
REQ-007 Port: flag_we  in  1  latches gt/lt/eq into the flag register (CMP executes).
REQ-008 Port: br_valid  in  1  branch request valid.
REQ-009 Port: br_ready  out  1  block can accept a branch request.
REQ-010 Port: br_cond  in  3  condition code: 000 AL, 001 EQ, 010 NE, 011 LT, 100 GT, 101 LE, 110 GE, 111 NV.
REQ-011 Port: pc  in  DATA_W  PC of the branch instruction.
REQ-012 Port: offset  in  OFF_W  two's-complement branch displacement.
REQ-013 Port: res_valid  out  1  one-cycle result strobe.
REQ-014 Port: taken  out  1  branch decision, qualified by res_valid.
REQ-015 Port: target  out  DATA_W  next PC, qualified by res_valid.
REQ-016 Port: flush  out  1  squash signal to fetch/decode.
REQ-017 Port: flags  out  3  registered {gt,lt,eq}.

Function
REQ-018 flag_we=1 SHALL load {gt,lt,eq} into the flag register at the clock edge, in any state.
REQ-019 The FSM SHALL have states IDLE, RESOLVE, FLUSH.
REQ-020 br_ready SHALL be 1 only in IDLE.
REQ-021 br_valid&br_ready at an edge SHALL latch br_cond, pc and offset and move IDLE->RESOLVE.
REQ-022 Without an accept, IDLE SHALL persist; br_valid outside IDLE SHALL be ignored (upstream holds it).
REQ-023 In RESOLVE the condition SHALL be evaluated against the flag register's current value: EQ=eq, NE=~eq, LT=lt, GT=gt, LE=lt|eq, GE=gt|eq, AL=1, NV=0.
REQ-024 Consequence: flag_we in the accept cycle IS seen by the branch; flag_we in the RESOLVE cycle is NOT seen.
REQ-025 In RESOLVE, res_valid SHALL be 1 for exactly one cycle with taken set per REQ-023.
REQ-026 Taken target SHALL be pc + sign-extended offset, modulo 2^DATA_W (wrap, no overflow flag).
REQ-027 Not-taken target SHALL be pc + 1, modulo 2^DATA_W.
REQ-028 RESOLVE SHALL go to FLUSH if taken, else to IDLE.
REQ-029 In FLUSH, flush SHALL be 1 for exactly FLUSH_CYCLES consecutive cycles via a down-counter, then return to IDLE.
REQ-030 Branch latency: accept edge to res_valid SHALL be 1 cycle; minimum request spacing 2 cycles (not taken) or 2+FLUSH_CYCLES (taken).
REQ-031 Flag combinations with several or no bits set SHALL be evaluated literally per REQ-023, with no error signal.
REQ-032 When res_valid=0, taken and target SHALL be 0.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, flag register 000, flush counter 0, and outputs res_valid=0, taken=0, target=0, flush=0, flags=000.
REQ-034 br_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-035 Reset in RESOLVE or FLUSH SHALL abort the operation with no res_valid or flush emitted afterwards.

Structure
REQ-036 A shared package SHALL hold the condition-code constants, FSM state encoding and the default widths.
REQ-037 Condition evaluation SHALL be a combinational sub-module branch_cond_eval (inputs cond, flags; output taken).

Verification
REQ-038 Reset, then CMP with gt=0,lt=0,eq=1 (flag_we), then BEQ pc=0x00100, offset=+5 -> res_valid one cycle later, taken=1, target=0x00105, flush high exactly 2 cycles, br_ready low for 3 cycles.
REQ-039 flags lt=1, BGE pc=0x3FFFF, offset=+3 -> taken=0, target=0x00000 (wrap), no flush, br_ready back next cycle.
REQ-040 BLT pc=0x00010, offset=-16 (0x3F0) with flag_we lt=1 in the accept cycle -> taken=1, target=0x00000; and flag_we eq=1 during RESOLVE instead -> the decision uses the old flags.
REQ-041 Sweep all 8 br_cond values against each of the 3 one-hot flag patterns -> taken matches the REQ-023 truth table (24 checks).
REQ-042 Assert rst in the 2nd FLUSH cycle -> flush drops asynchronously, flags=000, and br_ready=1 in the first cycle after release.
